// File: rtl/poly5_mac_pipe.sv
// poly5_mac_pipe: pipelined signed MUL / MADD / ACC unit
// feeding result write-back of the poly5 evaluation loop.
module poly5_mac_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int din2_WIDTH = 32,
  parameter int dout_WIDTH = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_vld,
  input  logic [1:0]            mode,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic [din2_WIDTH-1:0] din2,
  output logic                  out_vld,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PW  = din0_WIDTH + din1_WIDTH;
  localparam int D   = NUM_STAGE - 2;
  localparam int MSB = dout_WIDTH - 1;
  localparam int SW  = 3 + din2_WIDTH + dout_WIDTH;

  localparam logic [1:0] M_MUL  = 2'b00;
  localparam logic [1:0] M_MADD = 2'b01;
  localparam logic [1:0] M_ACC  = 2'b10;
  localparam logic [1:0] M_CLR  = 2'b11;

  logic                         s1_vld;
  logic [1:0]                   s1_mode;
  logic signed [din0_WIDTH-1:0] s1_a;
  logic signed [din1_WIDTH-1:0] s1_b;
  logic signed [din2_WIDTH-1:0] s1_c;

  // stage 1: capture the operand beat
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_mode <= M_MUL;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_c    <= '0;
    end else if (ce) begin
      s1_vld  <= in_vld;
      s1_mode <= mode;
      s1_a    <= din0;
      s1_b    <= din1;
      s1_c    <= din2;
    end
  end

  logic signed [PW-1:0]         prod;
  logic signed [dout_WIDTH-1:0] prod_x;
  logic [SW-1:0]                s1_word;
  logic [SW-1:0]                f_word;

  assign prod    = PW'(s1_a) * PW'(s1_b);
  assign prod_x  = dout_WIDTH'(prod);
  assign s1_word = {s1_vld, s1_mode, s1_c, prod_x};

  // Product and side-band travel together as one packed word.
  if (D > 0) begin : g_pipe
    logic [SW-1:0] st_q [D];
    for (genvar i = 0; i < D; i++) begin : g_st
      logic [SW-1:0] st_in;
      if (i == 0) begin : g_head
        assign st_in = s1_word;
      end else begin : g_body
        assign st_in = st_q[i-1];
      end
      // advance one product pipeline stage
      always_ff @(posedge clk) begin
        if (reset) begin
          st_q[i] <= '0;
        end else if (ce) begin
          st_q[i] <= st_in;
        end
      end
    end
    assign f_word = st_q[D-1];
  end else begin : g_flat
    assign f_word = s1_word;
  end

  logic                         f_vld;
  logic [1:0]                   f_mode;
  logic signed [din2_WIDTH-1:0] f_c;
  logic signed [dout_WIDTH-1:0] f_p;
  logic signed [dout_WIDTH-1:0] c_x;
  logic signed [dout_WIDTH-1:0] acc;
  logic signed [dout_WIDTH-1:0] add_a;
  logic signed [dout_WIDTH-1:0] add_b;
  logic signed [dout_WIDTH-1:0] sum;
  logic                         add_ovf;

  assign {f_vld, f_mode, f_c, f_p} = f_word;
  assign c_x = dout_WIDTH'(f_c);

  // final-stage operand select and wrapping add
  always_comb begin
    add_a = f_p;
    add_b = '0;
    case (f_mode)
      M_MADD: add_b = c_x;
      M_ACC: begin
        add_a = acc;
        add_b = f_p;
      end
      default: ;
    endcase
    sum     = add_a + add_b;
    add_ovf = (add_a[MSB] == add_b[MSB])
              && (sum[MSB] != add_a[MSB]);
  end

  // result registers and accumulator update
  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld <= 1'b0;
      dout    <= '0;
      ovf     <= 1'b0;
      acc     <= '0;
    end else if (ce) begin
      out_vld <= f_vld;
      if (f_vld) begin
        dout <= sum;
        ovf  <= add_ovf;
        if (f_mode == M_ACC || f_mode == M_CLR)
          acc <= sum;
      end
    end
  end

endmodule
